rgb_result_checker: RTL and testbench

//  Response-side checker for the RGB comparator interface. The RGB block takes 2-bit

---
 rtl/rgb_result_checker_if.sv | 30 +++
 rtl/rgb_result_checker.sv | 166 ++++++++++++++++
 tb/tb_rgb_result_checker.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_result_checker_if.sv
`default_nettype none
// ==========================================================================
// rgb_result_checker_if : sample stream and mismatch readout for the RGB checker
// Rev 1.0
// ==========================================================================
interface rgb_result_checker_if #(
  parameter int VEC_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [VEC_W-1:0]   in_a;
  logic [VEC_W-1:0]   in_b;
  logic               in_r;
  logic               in_g;
  logic               in_bout;
  logic               err_valid;
  logic               err_ready;
  logic [2*VEC_W+2:0] err_data;

  modport master (
    output in_valid, in_a, in_b, in_r, in_g, in_bout, err_ready,
    input  in_ready, err_valid, err_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_r, in_g, in_bout, err_ready,
    output in_ready, err_valid, err_data
  );
endinterface
`default_nettype wire

// File: rtl/rgb_result_checker.sv
`default_nettype none
// ==========================================================================
// rgb_result_checker : checks streamed RGB comparator samples, counts, covers,
// queues mismatches (mismatch FIFO built only with RGB_ERR_FIFO_EN). Rev 1.0
// ==========================================================================
module rgb_result_checker #(
  parameter int VEC_W      = 2,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  rgb_result_checker_if.slave   sif,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  cov_done,
  output logic [1:0]            state,
  output logic                  err_overflow
);
  localparam int N_PAIRS = 1 << (2 * VEC_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;
  logic [N_PAIRS-1:0]   cov_q, cov_d;
  logic                 cov_done_q, cov_done_d;
  logic                 accept;
  logic                 sample_pass;
  logic                 cov_full;
  logic [2:0]           exp_rgb;
  logic [2*VEC_W-1:0]   pair_idx;

  assign sif.in_ready = rst_n & ~clear;
  assign accept       = sif.in_valid & sif.in_ready;
  assign exp_rgb      = {sif.in_a > sif.in_b, sif.in_a == sif.in_b, sif.in_a < sif.in_b};
  assign sample_pass  = ({sif.in_r, sif.in_g, sif.in_bout} == exp_rgb);
  assign pair_idx     = {sif.in_a, sif.in_b};

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    cov_d      = cov_q;
    if (accept) begin
      cov_d[pair_idx] = 1'b1;
      if (sample_pass && pass_cnt_q != {CNT_W{1'b1}})
        pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (!sample_pass && fail_cnt_q != {CNT_W{1'b1}})
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
    cov_full   = &cov_d;
    cov_done_d = cov_done_q | cov_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      cov_q      <= '0;
      cov_done_q <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      cov_q      <= cov_d;
      cov_done_q <= cov_done_d;
    end
  end

  // DONE is terminal; only reset or clear returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= S_IDLE;
    end else if (accept) begin
      case (state_q)
        S_IDLE:   state_q <= cov_full ? S_DONE : S_ACTIVE;
        S_ACTIVE: if (cov_full) state_q <= S_DONE;
        default:  state_q <= state_q;
      endcase
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign cov_done = cov_done_q;
  assign state    = state_q;

`ifdef RGB_ERR_FIFO_EN
  localparam int DW = 2 * VEC_W + 3;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_valid_q, err_valid_d;
  logic [DW-1:0] err_data_q, err_data_d;
  logic          ovf_q, ovf_d;
  logic          push_req, push, pop, full;

  assign push_req = accept & ~sample_pass;
  assign pop      = err_valid_q & sif.err_ready;
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req & full & ~pop);
    if (push) begin
      mem_d[wr_ptr_q] = {sif.in_a, sif.in_b, sif.in_r, sif.in_g, sif.in_bout};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    err_valid_d = (count_d != '0);
    err_data_d  = err_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_data_q  <= err_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sif.err_valid = err_valid_q;
  assign sif.err_data  = err_data_q;
  assign err_overflow  = ovf_q;
`else
  logic unused_err_ready;
  assign unused_err_ready = sif.err_ready;
  assign sif.err_valid    = 1'b0;
  assign sif.err_data     = '0;
  assign err_overflow     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_result_checker.sv
`default_nettype none
// ==========================================================================
// tb_rgb_result_checker : directed self-checking bench for rgb_result_checker
// Rev 1.0
// ==========================================================================
module tb_rgb_result_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] pass_cnt, fail_cnt;
  logic       cov_done, err_overflow;
  logic [1:0] state;
  int         n_checks = 0;
  int         n_pass   = 0;

`ifdef RGB_ERR_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  rgb_result_checker_if #(.VEC_W(2)) sif ();

  rgb_result_checker #(.VEC_W(2), .CNT_W(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sif          (sif),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .cov_done     (cov_done),
    .state        (state),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] gold(input logic [1:0] a, input logic [1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] rgb,
                      input logic erdy);
    sif.in_valid  = 1'b1;
    sif.in_a      = a;
    sif.in_b      = b;
    {sif.in_r, sif.in_g, sif.in_bout} = rgb;
    sif.err_ready = erdy;
    @(posedge clk); #1;
    sif.in_valid  = 1'b0;
    sif.err_ready = 1'b0;
  endtask

  task automatic idle_cycle(input logic erdy);
    sif.in_valid  = 1'b0;
    sif.err_ready = erdy;
    @(posedge clk); #1;
    sif.err_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pass"},  32'(pass_cnt), 32'd0);
    check({tag, "_fail"},  32'(fail_cnt), 32'd0);
    check({tag, "_cov"},   32'(cov_done), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_evld"},  32'(sif.err_valid), 32'd0);
    check({tag, "_edata"}, 32'(sif.err_data), 32'd0);
    check({tag, "_ovf"},   32'(err_overflow), 32'd0);
  endtask

  // Failing samples {a,b,r,g,bout}; none matches the golden rule.
  logic [6:0] e [5];

  task automatic seven_samples();
    for (int i = 0; i < 7; i++) begin
      logic [3:0] p;
      p = 4'(i);
      if (i == 3) send(p[3:2], p[1:0], gold(p[3:2], p[1:0]) ^ 3'b111, 1'b0);
      else        send(p[3:2], p[1:0], gold(p[3:2], p[1:0]), 1'b0);
    end
  endtask

  initial begin
    e[0] = 7'b01_00_000;
    e[1] = 7'b10_10_111;
    e[2] = 7'b10_11_100;
    e[3] = 7'b11_11_011;
    e[4] = 7'b00_01_000;
    sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0;
    sif.in_r = 1'b0; sif.in_g = 1'b0; sif.in_bout = 1'b0; sif.err_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    check("rst_ready", 32'(sif.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_up", 32'(sif.in_ready), 32'd1);

    // Full golden sweep
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'(i);
      send(p[3:2], p[1:0], gold(p[3:2], p[1:0]), 1'b0);
      if (i == 0)  check("sweep_first_state", 32'(state), 32'd1);
      if (i == 14) begin
        check("sweep15_cov", 32'(cov_done), 32'd0);
        check("sweep15_state", 32'(state), 32'd1);
      end
    end
    check("sweep_pass", 32'(pass_cnt), 32'd16);
    check("sweep_fail", 32'(fail_cnt), 32'd0);
    check("sweep_cov", 32'(cov_done), 32'd1);
    check("sweep_state", 32'(state), 32'd2);
    send(2'd1, 2'd1, 3'b010, 1'b0);
    check("done_accepts", 32'(pass_cnt), 32'd17);
    check("done_stays", 32'(state), 32'd2);

    // Single mismatch, then all-zero and multi-hot responses
    do_clear();
    send(2'b10, 2'b01, 3'b010, 1'b0);
    check("mm_fail", 32'(fail_cnt), 32'd1);
    check("mm_state", 32'(state), 32'd1);
    check("mm_evld", 32'(sif.err_valid), 32'(FIFO_EN));
    check("mm_edata", 32'(sif.err_data), FIFO_EN ? 32'b10_01_010 : 32'd0);
    send(2'd0, 2'd0, 3'b000, 1'b0);
    send(2'd3, 2'd0, 3'b110, 1'b0);
    check("mm3_fail", 32'(fail_cnt), 32'd3);
    check("mm3_pass", 32'(pass_cnt), 32'd0);
    check("mm3_head", 32'(sif.err_data), FIFO_EN ? 32'b10_01_010 : 32'd0);
    idle_cycle(1'b1);
    check("pop1_evld", 32'(sif.err_valid), 32'(FIFO_EN));
    check("pop1_edata", 32'(sif.err_data), 32'd0);
    idle_cycle(1'b1);
    check("pop2_edata", 32'(sif.err_data), FIFO_EN ? 32'b11_00_110 : 32'd0);
    idle_cycle(1'b1);
    check("pop3_evld", 32'(sif.err_valid), 32'd0);
    idle_cycle(1'b1);
    check("pop_empty_evld", 32'(sif.err_valid), 32'd0);
    check("pop_empty_edata", 32'(sif.err_data), 32'd0);

    // Overflow: five mismatches into a depth-4 FIFO, no pops
    do_clear();
    for (int k = 0; k < 5; k++) begin
      send(e[k][6:5], e[k][4:3], e[k][2:0], 1'b0);
      if (k == 3) check("ovf4_flag", 32'(err_overflow), 32'd0);
    end
    check("ovf_fail", 32'(fail_cnt), 32'd5);
    check("ovf_flag", 32'(err_overflow), 32'(FIFO_EN));
    check("ovf_evld", 32'(sif.err_valid), 32'(FIFO_EN));
    check("ovf_head", 32'(sif.err_data), FIFO_EN ? 32'(e[0]) : 32'd0);

    // Full FIFO with simultaneous push and pop
    do_clear();
    for (int k = 0; k < 4; k++) send(e[k][6:5], e[k][4:3], e[k][2:0], 1'b0);
    send(e[4][6:5], e[4][4:3], e[4][2:0], 1'b1);
    check("pp_fail", 32'(fail_cnt), 32'd5);
    check("pp_ovf", 32'(err_overflow), 32'd0);
    check("pp_head", 32'(sif.err_data), FIFO_EN ? 32'(e[1]) : 32'd0);
    for (int k = 2; k < 5; k++) begin
      idle_cycle(1'b1);
      check($sformatf("pp_drain%0d", k), 32'(sif.err_data), FIFO_EN ? 32'(e[k]) : 32'd0);
    end
    check("pp_last_evld", 32'(sif.err_valid), 32'(FIFO_EN));
    idle_cycle(1'b1);
    check("pp_empty_evld", 32'(sif.err_valid), 32'd0);
    check("pp_empty_edata", 32'(sif.err_data), 32'd0);

    // Counter saturation
    do_clear();
    for (int i = 0; i < 256; i++) begin
      logic [3:0] p;
      p = 4'(i);
      send(p[3:2], p[1:0], gold(p[3:2], p[1:0]), 1'b0);
    end
    check("sat_pass", 32'(pass_cnt), 32'd255);
    check("sat_fail", 32'(fail_cnt), 32'd0);
    check("sat_cov", 32'(cov_done), 32'd1);
    check("sat_state", 32'(state), 32'd2);

    // Reset mid-sweep with a sample in flight
    do_clear();
    seven_samples();
    check("mid_pass", 32'(pass_cnt), 32'd6);
    check("mid_fail", 32'(fail_cnt), 32'd1);
    check("mid_evld", 32'(sif.err_valid), 32'(FIFO_EN));
    rst_n = 1'b0;
    sif.in_valid = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    check("midrst_ready", 32'(sif.in_ready), 32'd0);
    rst_n = 1'b1;
    sif.in_valid = 1'b0;

    // Clear mid-sweep with a sample in flight
    seven_samples();
    check("mid2_state", 32'(state), 32'd1);
    clear = 1'b1;
    sif.in_valid = 1'b1;
    #1;
    check("clr_ready", 32'(sif.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    sif.in_valid = 1'b0;
    check_zero("midclr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
